// File: rtl/count_pkg.sv
// Shared definitions for the counter-capture FIFO: default widths and the count type.
package count_pkg;

  localparam int COUNT_WIDTH   = 8;
  localparam int CAPTURE_DEPTH = 4;

  typedef logic [COUNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/count_capture_fifo_if.sv
// Valid/ready drain stream of the capture FIFO; master is the FIFO, slave the consumer.
interface count_capture_fifo_if #(
  parameter int WIDTH = count_pkg::COUNT_WIDTH
);

  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/edge_sync.sv
// Optional 2-flop trigger synchroniser (COUNT_CAPTURE_SYNC_EN) followed by a
// rising-edge detector that emits a single-cycle push request.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic push_req
);

  logic trig_s;
  logic trig_q, trig_d;

`ifdef COUNT_CAPTURE_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], trig};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign trig_s = sync_q[1];
`else
  assign trig_s = trig;
`endif

  always_comb begin
    trig_d = trig_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig_d;
    end
  end

  // Combinational so an unsynchronised trigger captures in its own rising cycle.
  assign push_req = trig_s & ~trig_q;

endmodule

// File: rtl/count_capture_fifo.sv
// Snapshots counter_value on each trigger rising edge into a small FIFO drained
// by valid/ready. Define COUNT_CAPTURE_SYNC_EN to synchronise an asynchronous trig.
module count_capture_fifo
  import count_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH,
  parameter int DEPTH = CAPTURE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         counter_value,
  input  logic                     trig,
  count_capture_fifo_if.master     out_if,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic             push_req;
  logic             pop;
  logic             full;
  logic             push_ok;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;

  edge_sync u_edge_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .trig     (trig),
    .push_req (push_req)
  );

  assign full    = (level_q == LW'(DEPTH));
  assign pop     = (level_q != '0) && out_if.out_ready;
  // When full, a push only fits if the head leaves in the same cycle.
  assign push_ok = push_req && (!full || pop);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = counter_value;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_if.out_data  = mem_q[rd_ptr_q];
  assign out_if.out_valid = (level_q != '0);
  assign level            = level_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed bench for count_capture_fifo (default build, trig synchronous to clk).
module tb_count_capture_fifo;
  import count_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  count_t     counter_value;
  logic       trig;
  logic [2:0] level;
  logic       overflow;
  logic       clr_overflow;

  int checks = 0;
  int errors = 0;

  count_capture_fifo_if #(.WIDTH(COUNT_WIDTH)) bus ();

  count_capture_fifo #(.WIDTH(COUNT_WIDTH), .DEPTH(CAPTURE_DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .counter_value (counter_value),
    .trig          (trig),
    .out_if        (bus.master),
    .level         (level),
    .overflow      (overflow),
    .clr_overflow  (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One trigger pulse: high for one cycle then low for one, no pops.
  task automatic capture(input count_t v);
    counter_value = v;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    counter_value = v + 8'd1;
    tick();
  endtask

  count_t wrap_vals [10];
  int     pop_idx;

  initial begin
    rst_n = 1'b0; trig = 1'b0; counter_value = '0; clr_overflow = 1'b0;
    bus.out_ready = 1'b0;

    // Reset then idle
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_valid", bus.out_valid, 0);
      check("idle_level", level, 0);
      check("idle_ovf", overflow, 0);
      check("idle_data", bus.out_data, 0);
    end
    $display("reset/idle: level=%0d valid=%0d", level, bus.out_valid);

    // Single capture
    counter_value = 8'd37; trig = 1'b1;
    tick();
    check("single_valid", bus.out_valid, 1);
    check("single_data", bus.out_data, 37);
    check("single_level", level, 1);
    trig = 1'b0; bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("single_pop_valid", bus.out_valid, 0);
    check("single_pop_level", level, 0);
    $display("single capture: data=37 popped, level=%0d", level);

    // Held trigger: one entry only
    counter_value = 8'd55; trig = 1'b1;
    tick();
    for (int i = 0; i < 19; i++) begin
      counter_value = 8'd56 + 8'(i);
      tick();
    end
    check("held_level", level, 1);
    check("held_data", bus.out_data, 55);
    trig = 1'b0;
    tick();
    check("held_level_after", level, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("held_drained", level, 0);
    $display("held trigger: one entry of 55");

    // Fill and overflow
    capture(8'd10); capture(8'd12); capture(8'd14); capture(8'd16); capture(8'd18);
    check("fill_level", level, 4);
    check("fill_ovf", overflow, 1);
    bus.out_ready = 1'b1;
    check("drain0", bus.out_data, 10); tick();
    check("drain1", bus.out_data, 12); tick();
    check("drain2", bus.out_data, 14); tick();
    check("drain3", bus.out_data, 16); tick();
    bus.out_ready = 1'b0;
    check("drain_empty_valid", bus.out_valid, 0);
    check("drain_empty_level", level, 0);
    check("ovf_sticky", overflow, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_cleared", overflow, 0);
    $display("fill/overflow: drained 10,12,14,16 overflow cleared");

    // Full push+pop
    capture(8'd100); capture(8'd101); capture(8'd102); capture(8'd103);
    check("full_level", level, 4);
    counter_value = 8'd200; trig = 1'b1; bus.out_ready = 1'b1;
    tick();
    trig = 1'b0;
    check("fullpp_level", level, 4);
    check("fullpp_ovf", overflow, 0);
    check("fullpp_d0", bus.out_data, 101); tick();
    check("fullpp_d1", bus.out_data, 102); tick();
    check("fullpp_d2", bus.out_data, 103); tick();
    check("fullpp_d3", bus.out_data, 200); tick();
    bus.out_ready = 1'b0;
    check("fullpp_empty", bus.out_valid, 0);
    $display("full push+pop: 101,102,103,200");

    // Wrap: push each round, pop on the following low cycle from round 1 on
    for (int i = 0; i < 10; i++) wrap_vals[i] = 8'd20 + 8'(3 * i);
    pop_idx = 0;
    for (int i = 0; i < 10; i++) begin
      counter_value = wrap_vals[i]; trig = 1'b1; bus.out_ready = 1'b0;
      tick();
      trig = 1'b0;
      if (i >= 1) begin
        check("wrap_data", bus.out_data, 32'(wrap_vals[pop_idx]));
        pop_idx++;
        bus.out_ready = 1'b1;
      end
      tick();
      bus.out_ready = 1'b0;
      $display("wrap round %0d: pushed %0d level=%0d", i, wrap_vals[i], level);
    end
    check("wrap_level", level, 1);
    check("wrap_head", bus.out_data, 32'(wrap_vals[9]));
    counter_value = 8'd99; trig = 1'b1;
    tick();
    trig = 1'b0;
    check("prereset_level", level, 2);

    // Asynchronous reset mid-stream, observed before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_valid", bus.out_valid, 0);
    check("areset_level", level, 0);
    check("areset_data", bus.out_data, 0);
    check("areset_ovf", overflow, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_level", level, 0);
    $display("mid-stream reset: level=%0d valid=%0d", level, bus.out_valid);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
